// File: rtl/ipdc_pkg.sv
// ipdc_pkg: shared types and helpers for the ipdc_win window display block.
//   - op_mode_e : operation codes on i_op_mode
//   - state_e   : controller FSM states (also exported on o_dbg_state)
//   - WIN_MIN_DEF / WIN_MAX_DEF : default window side limits
//   - gray_of   : luma approximation (R + 2G + B) >> 2 on zero-extended channels
package ipdc_pkg;

  localparam int WIN_MIN_DEF = 2;
  localparam int WIN_MAX_DEF = 4;

  typedef enum logic [3:0] {
    OP_LOAD     = 4'd0,
    OP_RIGHT    = 4'd1,
    OP_LEFT     = 4'd2,
    OP_UP       = 4'd3,
    OP_DOWN     = 4'd4,
    OP_ZOOM_OUT = 4'd5,
    OP_ZOOM_IN  = 4'd6,
    OP_GRAY     = 4'd7
  } op_mode_e;

  // S_DRAIN waits for the RAM/output pipeline to empty before reporting idle;
  // reserved ops also pass through it so o_op_ready drops for one cycle.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_DISP  = 2'd2,
    S_DRAIN = 2'd3
  } state_e;

  // Channels are passed zero-extended; the caller keeps the low C bits.
  function automatic logic [31:0] gray_of(input logic [31:0] r,
                                          input logic [31:0] g,
                                          input logic [31:0] b);
    return (r + (g << 1) + b) >> 2;
  endfunction

endpackage

// File: rtl/ipdc_frame_ram.sv
// ipdc_frame_ram: single-port frame store, synchronous read (read-first).
// Ports:
//   clk   : clock, rising edge
//   we    : write enable
//   addr  : shared read/write address
//   wdata : write data
//   rdata : registered read data, valid the cycle after addr is presented
// Contents are never reset.
module ipdc_frame_ram #(
  parameter int DEPTH = 256,
  parameter int AW    = 8,
  parameter int PIX_W = 24
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic [PIX_W-1:0] wdata,
  output logic [PIX_W-1:0] rdata
);

  logic [PIX_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/ipdc_win.sv
// ipdc_win: frame store with a movable/resizable square display window.
//
// A load op (mode 0) streams IMG_W*IMG_H pixels into the frame RAM in raster
// order; every other op adjusts the window origin (x,y) or side (win) when the
// result stays inside the frame, then streams the window's win*win pixels in
// raster order, one per cycle. Reserved modes return to idle after one cycle.
//
// Optional feature: define IPDC_GRAY_EN to make mode 7 display the window as
// gray {g,g,g} with g = (R + 2G + B) >> 2; without it mode 7 is reserved.
//
// Handshakes (op and pixel): a transfer happens on a rising edge where the
// valid input and the ready output are both high; valid is ignored while ready
// is low, and ready never depends combinationally on valid.
//
// Ports:
//   i_clk, i_rst        : clock; synchronous active-high reset
//   i_op_valid/i_op_mode: operation strobe and code; o_op_ready = idle
//   i_in_valid/i_in_data: pixel stream during load; o_in_ready = accepting
//   o_out_valid/o_out_data : window pixel stream
//   o_dbg_state         : current FSM state (state_e encoding)
module ipdc_win
  import ipdc_pkg::*;
#(
  parameter int IMG_W   = 16,
  parameter int IMG_H   = 16,
  parameter int PIX_W   = 24,
  parameter int WIN_MAX = WIN_MAX_DEF,
  parameter int WIN_MIN = WIN_MIN_DEF
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_op_valid,
  input  logic [3:0]       i_op_mode,
  output logic             o_op_ready,
  input  logic             i_in_valid,
  input  logic [PIX_W-1:0] i_in_data,
  output logic             o_in_ready,
  output logic             o_out_valid,
  output logic [PIX_W-1:0] o_out_data,
  output logic [1:0]       o_dbg_state
);

  localparam int C    = PIX_W / 3;
  localparam int XW   = $clog2(IMG_W);
  localparam int YW   = $clog2(IMG_H);
  localparam int AW   = XW + YW;
  localparam int NPIX = IMG_W * IMG_H;
  localparam int WW   = $clog2(WIN_MAX) + 1;

  state_e           state, next_state, op_next;
  logic [XW-1:0]    x, op_x;
  logic [YW-1:0]    y, op_y;
  logic [WW-1:0]    win, op_win;
  logic [WW-1:0]    r_cnt, c_cnt;
  logic [AW-1:0]    load_cnt, disp_addr, ram_addr;
  logic [PIX_W-1:0] ram_rdata, gray_pix;
  logic             rd_v, gray_sel, op_gray;
  logic             accept, pix_acc, last_load, last_col, last_pix;
  int               xi, yi, wi;

  assign xi = int'(x);
  assign yi = int'(y);
  assign wi = int'(win);

  assign accept    = (state == S_IDLE) && o_op_ready && i_op_valid;
  assign pix_acc   = (state == S_LOAD) && o_in_ready && i_in_valid;
  assign last_load = (load_cnt == AW'(NPIX - 1));
  assign last_col  = (c_cnt == win - WW'(1));
  assign last_pix  = last_col && (r_cnt == win - WW'(1));

  // Dimensions are powers of two, so row*IMG_W + col is a concatenation.
  assign disp_addr = {y + YW'(r_cnt), x + XW'(c_cnt)};
  assign ram_addr  = (state == S_LOAD) ? load_cnt : disp_addr;

  assign o_dbg_state = state;

  // Operation decode: candidate origin/window after the op, and where to go.
  always_comb begin
    op_x    = x;
    op_y    = y;
    op_win  = win;
    op_gray = 1'b0;
    op_next = S_DRAIN;
    case (i_op_mode)
      OP_LOAD: op_next = S_LOAD;
      OP_RIGHT: begin
        op_next = S_DISP;
        if (xi + wi + 1 <= IMG_W) op_x = x + XW'(1);
      end
      OP_LEFT: begin
        op_next = S_DISP;
        if (xi > 0) op_x = x - XW'(1);
      end
      OP_UP: begin
        op_next = S_DISP;
        if (yi > 0) op_y = y - YW'(1);
      end
      OP_DOWN: begin
        op_next = S_DISP;
        if (yi + wi + 1 <= IMG_H) op_y = y + YW'(1);
      end
      OP_ZOOM_OUT: begin
        op_next = S_DISP;
        if (wi > WIN_MIN) op_win = win >> 1;
      end
      OP_ZOOM_IN: begin
        op_next = S_DISP;
        if (wi < WIN_MAX && xi + 2 * wi <= IMG_W && yi + 2 * wi <= IMG_H)
          op_win = win << 1;
      end
`ifdef IPDC_GRAY_EN
      OP_GRAY: begin
        op_next = S_DISP;
        op_gray = 1'b1;
      end
`endif
      default: op_next = S_DRAIN;
    endcase
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:  if (accept) next_state = op_next;
      S_LOAD:  if (pix_acc && last_load) next_state = S_DISP;
      S_DISP:  if (last_pix) next_state = S_DRAIN;
      S_DRAIN: if (!rd_v) next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // Gray conversion of the RAM word on its way to the output register.
  logic [31:0]  gray_full;
  logic [C-1:0] gray_ch;
  logic         gray_unused;

  assign gray_full   = gray_of(32'(ram_rdata[3*C-1:2*C]),
                               32'(ram_rdata[2*C-1:C]),
                               32'(ram_rdata[C-1:0]));
  assign gray_ch     = gray_full[C-1:0];
  assign gray_unused = ^gray_full[31:C];
  assign gray_pix    = {gray_ch, gray_ch, gray_ch};

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state       <= S_IDLE;
      x           <= '0;
      y           <= '0;
      win         <= WW'(WIN_MAX);
      r_cnt       <= '0;
      c_cnt       <= '0;
      load_cnt    <= '0;
      rd_v        <= 1'b0;
      gray_sel    <= 1'b0;
      o_op_ready  <= 1'b0;
      o_in_ready  <= 1'b0;
      o_out_valid <= 1'b0;
      o_out_data  <= '0;
    end else begin
      state       <= next_state;
      o_op_ready  <= (next_state == S_IDLE);
      // Holding ready low on the accept edge delays it to one cycle after.
      o_in_ready  <= (state == S_LOAD) && (next_state == S_LOAD);
      rd_v        <= (state == S_DISP);
      o_out_valid <= rd_v;
      o_out_data  <= rd_v ? (gray_sel ? gray_pix : ram_rdata) : '0;

      if (accept) begin
        x        <= op_x;
        y        <= op_y;
        win      <= op_win;
        gray_sel <= op_gray;
        r_cnt    <= '0;
        c_cnt    <= '0;
        load_cnt <= '0;
      end

      if (pix_acc) begin
        load_cnt <= load_cnt + AW'(1);
        if (last_load) begin
          x     <= '0;
          y     <= '0;
          win   <= WW'(WIN_MAX);
          r_cnt <= '0;
          c_cnt <= '0;
        end
      end

      if (state == S_DISP) begin
        if (last_col) begin
          c_cnt <= '0;
          r_cnt <= r_cnt + WW'(1);
        end else begin
          c_cnt <= c_cnt + WW'(1);
        end
      end
    end
  end

  ipdc_frame_ram #(
    .DEPTH(NPIX),
    .AW   (AW),
    .PIX_W(PIX_W)
  ) u_ram (
    .clk  (i_clk),
    .we   (pix_acc),
    .addr (ram_addr),
    .wdata(i_in_data),
    .rdata(ram_rdata)
  );

endmodule

// File: tb/tb_ipdc_win.sv
// tb_ipdc_win: directed self-checking bench for ipdc_win (16x16 frame,
// 24-bit pixels, window 2..4). Frame contents are tracked in frame_m; window
// expectations are derived from it and from hand-computed constants.
module tb_ipdc_win;
  import ipdc_pkg::*;

  localparam int PIX_W = 24;
  localparam int NPIX  = 256;

  logic             i_clk = 1'b0;
  logic             i_rst = 1'b1;
  logic             i_op_valid = 1'b0;
  logic [3:0]       i_op_mode = 4'd0;
  logic             o_op_ready;
  logic             i_in_valid = 1'b0;
  logic [PIX_W-1:0] i_in_data = '0;
  logic             o_in_ready;
  logic             o_out_valid;
  logic [PIX_W-1:0] o_out_data;
  logic [1:0]       o_dbg_state;

  ipdc_win dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_op_valid (i_op_valid),
    .i_op_mode  (i_op_mode),
    .o_op_ready (o_op_ready),
    .i_in_valid (i_in_valid),
    .i_in_data  (i_in_data),
    .o_in_ready (o_in_ready),
    .o_out_valid(o_out_valid),
    .o_out_data (o_out_data),
    .o_dbg_state(o_dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 i_clk = ~i_clk;

  int checks = 0;
  int errors = 0;

  logic [PIX_W-1:0] frame_m [NPIX];
  logic [PIX_W-1:0] exp_q[$];
  logic [PIX_W-1:0] got_q[$];
  int first_n, last_n, ready_n;
  bit gap_seen;

  task automatic pulse_reset();
    i_rst = 1'b1;
    @(posedge i_clk); #1;
    i_rst = 1'b0;
    @(posedge i_clk); #1;
  endtask

  // ---------------- driver tasks ----------------
  // Returns 1 ns after the accepting edge.
  task automatic issue_op(input logic [3:0] mode);
    int t;
    t = 0;
    while (!o_op_ready && t < 200) begin
      @(posedge i_clk); #1;
      t++;
    end
    if (!o_op_ready) begin
      checks++; errors++;
      $display("FAIL op_ready_wait: o_op_ready=%0b after %0d cycles, required 1", o_op_ready, t);
    end
    i_op_valid = 1'b1;
    i_op_mode  = mode;
    @(posedge i_clk); #1;
    i_op_valid = 1'b0;
  endtask

  // Streams frame_m after o_in_ready is up; one bubble at pixel 100.
  task automatic stream_pixels();
    for (int i = 0; i < NPIX; i++) begin
      int t;
      if (i == 100) begin
        i_in_valid = 1'b0;
        @(posedge i_clk); #1;
      end
      i_in_valid = 1'b1;
      i_in_data  = frame_m[i];
      t = 0;
      while (!o_in_ready && t < 50) begin
        @(posedge i_clk); #1;
        t++;
      end
      if (!o_in_ready) begin
        checks++; errors++;
        $display("FAIL in_ready_wait: pixel %0d never accepted", i);
        i_in_valid = 1'b0;
        return;
      end
      @(posedge i_clk); #1;
    end
    i_in_valid = 1'b0;
  endtask

  // Records window outputs; n counts edges after the reference edge.
  task automatic capture();
    got_q.delete();
    first_n = -1; last_n = -1; ready_n = -1; gap_seen = 0;
    for (int n = 1; n <= 200; n++) begin
      @(posedge i_clk); #1;
      if (o_out_valid) begin
        if (last_n >= 0 && last_n != n - 1) gap_seen = 1;
        if (first_n < 0) first_n = n;
        last_n = n;
        got_q.push_back(o_out_data);
      end
      if (o_op_ready) begin
        ready_n = n;
        break;
      end
    end
  endtask

  // Expected window from the frame model, raster order.
  function automatic void build_exp(input int x, input int y, input int w, input bit gray);
    exp_q.delete();
    for (int r = 0; r < w; r++) begin
      for (int c = 0; c < w; c++) begin
        logic [PIX_W-1:0] p;
        int g;
        p = frame_m[(y + r) * 16 + (x + c)];
        g = (int'(p[23:16]) + 2 * int'(p[15:8]) + int'(p[7:0])) >> 2;
        if (gray) p = {g[7:0], g[7:0], g[7:0]};
        exp_q.push_back(p);
      end
    end
  endfunction

  // ---------------- scenario tasks ----------------
  task automatic test_reset();
    i_rst = 1'b1;
    repeat (3) @(posedge i_clk);
    #1;
    checks++; if (o_op_ready !== 1'b0) begin errors++; $display("FAIL reset_op_ready: got %0b exp 0", o_op_ready); end
    checks++; if (o_in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %0b exp 0", o_in_ready); end
    checks++; if (o_out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %0b exp 0", o_out_valid); end
    checks++; if (o_out_data !== '0) begin errors++; $display("FAIL reset_out_data: got %h exp 0", o_out_data); end
    checks++; if (o_dbg_state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d exp 0", o_dbg_state); end
    i_rst = 1'b0;
    @(posedge i_clk); #1;
    checks++; if (o_op_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready: got %0b exp 1", o_op_ready); end
  endtask

  task automatic test_load();
    for (int i = 0; i < NPIX; i++) frame_m[i] = PIX_W'(i);
    issue_op(4'd0);
    checks++; if (o_op_ready !== 1'b0) begin errors++; $display("FAIL load_ready_drop: got %0b exp 0", o_op_ready); end
    checks++; if (o_in_ready !== 1'b0) begin errors++; $display("FAIL load_in_ready_k: got %0b exp 0", o_in_ready); end
    @(posedge i_clk); #1;
    checks++; if (o_in_ready !== 1'b1) begin errors++; $display("FAIL load_in_ready_k1: got %0b exp 1", o_in_ready); end
    stream_pixels();
    checks++; if (o_in_ready !== 1'b0) begin errors++; $display("FAIL load_in_ready_end: got %0b exp 0", o_in_ready); end
    capture();
    exp_q.delete();
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) exp_q.push_back(PIX_W'(r * 16 + c));
    checks++; if (first_n !== 2) begin errors++; $display("FAIL load_latency: first valid at edge %0d exp 2", first_n); end
    checks++; if (got_q.size() !== 16) begin errors++; $display("FAIL load_count: got %0d exp 16", got_q.size()); end
    checks++; if (gap_seen) begin errors++; $display("FAIL load_gap: valid not contiguous"); end
    checks++; if (ready_n !== last_n + 1) begin errors++; $display("FAIL load_ready_after: ready at %0d exp %0d", ready_n, last_n + 1); end
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL load_pix[%0d]: got %h exp %h", i, (i < got_q.size()) ? got_q[i] : 'x, exp_q[i]);
      end
    end
  endtask

  task automatic test_shift();
    // right: (0,0) -> (1,0)
    issue_op(4'd1);
    capture();
    build_exp(1, 0, 4, 0);
    checks++; if (first_n !== 2) begin errors++; $display("FAIL right_latency: got %0d exp 2", first_n); end
    checks++; if (got_q.size() !== 16) begin errors++; $display("FAIL right_count: got %0d exp 16", got_q.size()); end
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin errors++; $display("FAIL right_pix[%0d]: exp %h", i, exp_q[i]); end
    end
    checks++; if (got_q.size() == 16 && got_q[15] !== 24'd52) begin errors++; $display("FAIL right_last: got %h exp 34", got_q[15]); end
    // left twice: back to (0,0), then blocked at the edge
    for (int k = 0; k < 2; k++) begin
      issue_op(4'd2);
      capture();
      build_exp(0, 0, 4, 0);
      checks++; if (got_q.size() !== 16) begin errors++; $display("FAIL left%0d_count: got %0d exp 16", k, got_q.size()); end
      for (int i = 0; i < 16; i++) begin
        checks++;
        if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin errors++; $display("FAIL left%0d_pix[%0d]: exp %h", k, i, exp_q[i]); end
      end
    end
  endtask

  task automatic test_bounds();
    for (int k = 0; k < 24; k++) begin
      issue_op((k < 12) ? 4'd1 : 4'd4);
      capture();
      checks++; if (got_q.size() !== 16) begin errors++; $display("FAIL walk%0d_count: got %0d exp 16", k, got_q.size()); end
    end
    // at (12,12): right and down are both blocked
    for (int k = 0; k < 2; k++) begin
      issue_op((k == 0) ? 4'd1 : 4'd4);
      capture();
      build_exp(12, 12, 4, 0);
      checks++; if (got_q.size() !== 16) begin errors++; $display("FAIL edge%0d_count: got %0d exp 16", k, got_q.size()); end
      else begin
        checks++; if (got_q[0] !== 24'd204) begin errors++; $display("FAIL edge%0d_first: got %0d exp 204", k, got_q[0]); end
        checks++; if (got_q[15] !== 24'd255) begin errors++; $display("FAIL edge%0d_last: got %0d exp 255", k, got_q[15]); end
        for (int i = 0; i < 16; i++) begin
          checks++;
          if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL edge%0d_pix[%0d]: got %h exp %h", k, i, got_q[i], exp_q[i]); end
        end
      end
    end
  endtask

  task automatic test_zoom();
    pulse_reset();
    // up at row 0 is blocked
    issue_op(4'd3);
    capture();
    checks++; if (got_q.size() !== 16 || got_q[0] !== 24'd0) begin errors++; $display("FAIL up_edge: count %0d exp 16, first must be 0", got_q.size()); end
    // zoom out twice: 2x2 at (0,0) -> 0,1,16,17
    for (int k = 0; k < 2; k++) begin
      issue_op(4'd5);
      capture();
      checks++; if (got_q.size() !== 4) begin errors++; $display("FAIL zout%0d_count: got %0d exp 4", k, got_q.size()); end
      else begin
        checks++;
        if (got_q[0] !== 24'd0 || got_q[1] !== 24'd1 || got_q[2] !== 24'd16 || got_q[3] !== 24'd17) begin
          errors++;
          $display("FAIL zout%0d_pix: got %0d %0d %0d %0d exp 0 1 16 17", k, got_q[0], got_q[1], got_q[2], got_q[3]);
        end
      end
      checks++; if (ready_n !== last_n + 1) begin errors++; $display("FAIL zout%0d_ready: at %0d exp %0d", k, ready_n, last_n + 1); end
    end
    // zoom in twice: 4x4 both times
    for (int k = 0; k < 2; k++) begin
      issue_op(4'd6);
      capture();
      build_exp(0, 0, 4, 0);
      checks++; if (got_q.size() !== 16) begin errors++; $display("FAIL zin%0d_count: got %0d exp 16", k, got_q.size()); end
      else begin
        for (int i = 0; i < 16; i++) begin
          checks++;
          if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL zin%0d_pix[%0d]: got %h exp %h", k, i, got_q[i], exp_q[i]); end
        end
      end
    end
    // zoom in blocked by the right edge: 2x2 at x=14
    issue_op(4'd5);
    capture();
    for (int k = 0; k < 14; k++) begin
      issue_op(4'd1);
      capture();
    end
    issue_op(4'd6);
    capture();
    checks++; if (got_q.size() !== 4) begin errors++; $display("FAIL zin_edge_count: got %0d exp 4", got_q.size()); end
    else begin
      checks++;
      if (got_q[0] !== 24'd14 || got_q[1] !== 24'd15 || got_q[2] !== 24'd30 || got_q[3] !== 24'd31) begin
        errors++;
        $display("FAIL zin_edge_pix: got %0d %0d %0d %0d exp 14 15 30 31", got_q[0], got_q[1], got_q[2], got_q[3]);
      end
    end
  endtask

  task automatic test_gray();
`ifdef IPDC_GRAY_EN
    for (int i = 0; i < NPIX; i++) frame_m[i] = PIX_W'(i);
    frame_m[0] = 24'h102030;
    issue_op(4'd0);
    stream_pixels();
    capture();
    issue_op(4'd7);
    capture();
    build_exp(0, 0, 4, 1);
    checks++; if (got_q.size() !== 16) begin errors++; $display("FAIL gray_count: got %0d exp 16", got_q.size()); end
    else begin
      checks++; if (got_q[0] !== 24'h202020) begin errors++; $display("FAIL gray_first: got %h exp 202020", got_q[0]); end
      checks++; if (got_q[5] !== 24'h040404) begin errors++; $display("FAIL gray_pix5: got %h exp 040404", got_q[5]); end
      for (int i = 0; i < 16; i++) begin
        checks++;
        if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL gray_pix[%0d]: got %h exp %h", i, got_q[i], exp_q[i]); end
      end
    end
`else
    issue_op(4'd7);
    checks++; if (o_op_ready !== 1'b0) begin errors++; $display("FAIL gray_off_drop: got %0b exp 0", o_op_ready); end
    capture();
    checks++; if (got_q.size() !== 0) begin errors++; $display("FAIL gray_off_output: got %0d pixels exp 0", got_q.size()); end
    checks++; if (ready_n !== 1) begin errors++; $display("FAIL gray_off_ready: at %0d exp 1", ready_n); end
`endif
  endtask

  task automatic test_reserved();
    for (int m = 8; m < 16; m += 7) begin
      issue_op(4'(m));
      checks++; if (o_op_ready !== 1'b0) begin errors++; $display("FAIL rsv%0d_drop: got %0b exp 0", m, o_op_ready); end
      capture();
      checks++; if (got_q.size() !== 0) begin errors++; $display("FAIL rsv%0d_output: got %0d pixels exp 0", m, got_q.size()); end
      checks++; if (ready_n !== 1) begin errors++; $display("FAIL rsv%0d_ready: at %0d exp 1", m, ready_n); end
    end
  endtask

  task automatic test_reset_mid();
    int t;
    issue_op(4'd4);
    t = 0;
    while (!o_out_valid && t < 20) begin
      @(posedge i_clk); #1;
      t++;
    end
    checks++; if (o_out_valid !== 1'b1) begin errors++; $display("FAIL rstmid_wait: o_out_valid=%0b exp 1", o_out_valid); end
    i_rst = 1'b1;
    @(posedge i_clk); #1;
    checks++; if (o_out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid: got %0b exp 0", o_out_valid); end
    checks++; if (o_op_ready !== 1'b0) begin errors++; $display("FAIL rstmid_ready: got %0b exp 0", o_op_ready); end
    checks++; if (o_dbg_state !== 2'd0) begin errors++; $display("FAIL rstmid_state: got %0d exp 0", o_dbg_state); end
    i_rst = 1'b0;
    @(posedge i_clk); #1;
    checks++; if (o_op_ready !== 1'b1) begin errors++; $display("FAIL rstmid_release: got %0b exp 1", o_op_ready); end
    issue_op(4'd1);
    capture();
    build_exp(1, 0, 4, 0);
    checks++; if (got_q.size() !== 16) begin errors++; $display("FAIL rstmid_count: got %0d exp 16", got_q.size()); end
    else begin
      checks++; if (got_q[0] !== 24'd1) begin errors++; $display("FAIL rstmid_first: got %0d exp 1", got_q[0]); end
      for (int i = 0; i < 16; i++) begin
        checks++;
        if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL rstmid_pix[%0d]: got %h exp %h", i, got_q[i], exp_q[i]); end
      end
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_load();
    test_shift();
    test_bounds();
    test_zoom();
    test_gray();
    test_reserved();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
